axis_demux: RTL

AXIS_DEMUX -- requirements
Module: axis_demux

---
 rtl/axis_pkg.sv | 11 +
 rtl/axis_demux_if.sv | 16 +
 rtl/axis_skid_buf.sv | 82 ++++++++
 rtl/axis_demux.sv | 108 ++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream demux slice: default data width and demux FSM states.
package axis_pkg;

   localparam int unsigned DATA_W_DEF = 8;

   typedef enum logic {
      IDLE = 1'b0,
      PKT  = 1'b1
   } state_t;

endpackage

// File: rtl/axis_demux_if.sv
// AXI-Stream handshake bundle (tdata/tvalid/tready/tlast) with master and slave views.
interface axis_demux_if
   import axis_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
);

   logic [DATA_W-1:0] tdata;
   logic              tvalid;
   logic              tready;
   logic              tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-Stream skid buffer: registered outputs and a registered upstream ready.
module axis_skid_buf
   import axis_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic         clk,
   input  logic         reset_n,
   axis_demux_if.slave  s_axis,
   axis_demux_if.master m_axis
);

   logic              head_valid, head_valid_n;
   logic [DATA_W-1:0] head_data, head_data_n;
   logic              head_last, head_last_n;
   logic              skid_valid, skid_valid_n;
   logic [DATA_W-1:0] skid_data, skid_data_n;
   logic              skid_last, skid_last_n;
   logic              ready_q;
   logic              push, pop;

   assign push = s_axis.tvalid & ready_q;
   assign pop  = head_valid & m_axis.tready;

   // The head register always holds the oldest beat; the skid entry only fills while the head is stalled.
   always_comb begin
      head_valid_n = head_valid;
      head_data_n  = head_data;
      head_last_n  = head_last;
      skid_valid_n = skid_valid;
      skid_data_n  = skid_data;
      skid_last_n  = skid_last;
      if (!head_valid || pop) begin
         if (skid_valid) begin
            head_valid_n = 1'b1;
            head_data_n  = skid_data;
            head_last_n  = skid_last;
            skid_valid_n = push;
            if (push) begin
               skid_data_n = s_axis.tdata;
               skid_last_n = s_axis.tlast;
            end
         end else begin
            head_valid_n = push;
            if (push) begin
               head_data_n = s_axis.tdata;
               head_last_n = s_axis.tlast;
            end
         end
      end else if (push) begin
         skid_valid_n = 1'b1;
         skid_data_n  = s_axis.tdata;
         skid_last_n  = s_axis.tlast;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         head_valid <= 1'b0;
         head_data  <= '0;
         head_last  <= 1'b0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         skid_last  <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         head_valid <= head_valid_n;
         head_data  <= head_data_n;
         head_last  <= head_last_n;
         skid_valid <= skid_valid_n;
         skid_data  <= skid_data_n;
         skid_last  <= skid_last_n;
         ready_q    <= ~skid_valid_n;
      end
   end

   assign s_axis.tready = ready_q;
   assign m_axis.tvalid = head_valid;
   assign m_axis.tdata  = head_data;
   assign m_axis.tlast  = head_last;

endmodule

// File: rtl/axis_demux.sv
// 1-to-2 AXI-Stream packet demux; destination chosen by sel at packet start and locked until tlast.
// Optional per-port completed-packet counters: define AXIS_DEMUX_PKT_CNT_EN.
module axis_demux
   import axis_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned PCNT_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              sel,
   input  logic [DATA_W-1:0] input_tdata,
   input  logic              input_tvalid,
   output logic              input_tready,
   input  logic              input_tlast,
   output logic [DATA_W-1:0] output_tdata_0,
   output logic              output_tvalid_0,
   input  logic              output_tready_0,
   output logic              output_tlast_0,
   output logic [DATA_W-1:0] output_tdata_1,
   output logic              output_tvalid_1,
   input  logic              output_tready_1,
   output logic              output_tlast_1
`ifdef AXIS_DEMUX_PKT_CNT_EN
   ,
   output logic [PCNT_W-1:0] pkt_cnt_0,
   output logic [PCNT_W-1:0] pkt_cnt_1
`endif
);

   if (PCNT_W == 0) begin : g_pcnt_w_check
      $error("axis_demux: PCNT_W must be at least 1");
   end

   state_t state;
   logic   dest;
   logic   tgt;
   logic   accept;

   axis_demux_if #(.DATA_W(DATA_W)) buf_in_0 ();
   axis_demux_if #(.DATA_W(DATA_W)) buf_in_1 ();
   axis_demux_if #(.DATA_W(DATA_W)) buf_out_0 ();
   axis_demux_if #(.DATA_W(DATA_W)) buf_out_1 ();

   // Ready depends only on sel and registered state, never on downstream tready.
   assign tgt          = (state == IDLE) ? sel : dest;
   assign input_tready = tgt ? buf_in_1.tready : buf_in_0.tready;
   assign accept       = input_tvalid & input_tready;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
         dest  <= 1'b0;
      end else if (accept) begin
         if (state == IDLE) begin
            dest  <= sel;
            state <= input_tlast ? IDLE : PKT;
         end else if (input_tlast) begin
            state <= IDLE;
         end
      end
   end

   assign buf_in_0.tdata  = input_tdata;
   assign buf_in_0.tlast  = input_tlast;
   assign buf_in_0.tvalid = input_tvalid & ~tgt;
   assign buf_in_1.tdata  = input_tdata;
   assign buf_in_1.tlast  = input_tlast;
   assign buf_in_1.tvalid = input_tvalid & tgt;

   axis_skid_buf #(.DATA_W(DATA_W)) u_buf_0 (
      .clk     (clk),
      .reset_n (reset_n),
      .s_axis  (buf_in_0),
      .m_axis  (buf_out_0)
   );

   axis_skid_buf #(.DATA_W(DATA_W)) u_buf_1 (
      .clk     (clk),
      .reset_n (reset_n),
      .s_axis  (buf_in_1),
      .m_axis  (buf_out_1)
   );

   assign output_tdata_0   = buf_out_0.tdata;
   assign output_tvalid_0  = buf_out_0.tvalid;
   assign output_tlast_0   = buf_out_0.tlast;
   assign buf_out_0.tready = output_tready_0;
   assign output_tdata_1   = buf_out_1.tdata;
   assign output_tvalid_1  = buf_out_1.tvalid;
   assign output_tlast_1   = buf_out_1.tlast;
   assign buf_out_1.tready = output_tready_1;

`ifdef AXIS_DEMUX_PKT_CNT_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pkt_cnt_0 <= '0;
         pkt_cnt_1 <= '0;
      end else begin
         if (output_tvalid_0 && output_tready_0 && output_tlast_0)
            pkt_cnt_0 <= pkt_cnt_0 + 1'b1;
         if (output_tvalid_1 && output_tready_1 && output_tlast_1)
            pkt_cnt_1 <= pkt_cnt_1 + 1'b1;
      end
   end
`endif

endmodule
